// File: rtl/async_edge_pkg.sv
// Shared definitions for the multi-channel asynchronous edge synchroniser:
// per-channel edge-mode codes, the hold-off state type and a counter-width
// helper. Optional edge counters are controlled by ASYNC_EDGE_COUNTER_EN.
package async_edge_pkg;

  // Edge mode code is {accept_rising, accept_falling}.
  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_RISE = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  typedef enum logic {
    HO_IDLE = 1'b0,
    HO_HOLD = 1'b1
  } ho_state_t;

  // Build a channel's edge mode from its EDGE_POS / EDGE_NEG bits.
  function automatic logic [1:0] edge_mode(input logic pos, input logic neg);
    return {pos, neg};
  endfunction

  // Bits needed to hold the value 'value' (never less than 1).
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) <= value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/async_edge_sync_multi_if.sv
// Bus bundle for async_edge_sync_multi: async flags and software controls in,
// pulses, sticky flags and edge counters out. The master side drives the
// controls; the slave side is the synchroniser itself.
interface async_edge_sync_multi_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);
  logic [NCH-1:0]       a_flag;
  logic [NCH-1:0]       clear;
  logic                 cnt_clr;
  logic [NCH-1:0]       pulse_out;
  logic [NCH-1:0]       pending;
  logic [NCH-1:0]       overrun;
  logic [NCH*CNT_W-1:0] edge_count;

  modport master (
    output a_flag, clear, cnt_clr,
    input  pulse_out, pending, overrun, edge_count
  );

  modport slave (
    input  a_flag, clear, cnt_clr,
    output pulse_out, pending, overrun, edge_count
  );
endinterface

// File: rtl/async_edge_sync_ch.sv
// One channel of the edge synchroniser: synchroniser chain, start-up mask,
// edge qualification, hold-off FSM, sticky pending/overrun flags and the
// optional accepted-edge counter (ASYNC_EDGE_COUNTER_EN).
module async_edge_sync_ch
  import async_edge_pkg::*;
#(
  parameter int         DEST_SYNC_FF = 4,
  parameter logic [1:0] MODE         = EDGE_RISE,
  parameter int         HOLDOFF      = 0,
  parameter int         CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_flag,
  input  logic             clear,
`ifdef ASYNC_EDGE_COUNTER_EN
  input  logic             cnt_clr,
`endif
  output logic             pulse_out,
  output logic             pending,
  output logic             overrun,
  output logic [CNT_W-1:0] edge_count
);

  localparam int FILL_W = clog2_min1(DEST_SYNC_FF);
  localparam int HOLD_W = clog2_min1(HOLDOFF);

  logic [DEST_SYNC_FF-1:0] sync_q;
  logic [FILL_W-1:0]       fill_q;
  logic                    fill_done;
  logic                    rise;
  logic                    fall;
  logic                    edge_hit;
  logic                    accept;
  logic                    drop;
  ho_state_t               ho_state;
  logic [HOLD_W-1:0]       hold_cnt;

  // Until every stage holds a post-reset sample, the reset value 0 would look
  // like a real prior level, so edges are masked while the chain fills.
  assign fill_done = (fill_q == FILL_W'(DEST_SYNC_FF));
  assign rise      = sync_q[DEST_SYNC_FF-2] & ~sync_q[DEST_SYNC_FF-1];
  assign fall      = ~sync_q[DEST_SYNC_FF-2] & sync_q[DEST_SYNC_FF-1];
  assign edge_hit  = fill_done & ((MODE[1] & rise) | (MODE[0] & fall));
  assign accept    = edge_hit & (ho_state == HO_IDLE);
  assign drop      = edge_hit & (ho_state == HO_HOLD);

  // Synchroniser chain (newest sample in bit 0) and start-up fill counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[DEST_SYNC_FF-2:0], a_flag};
      if (!fill_done) fill_q <= fill_q + FILL_W'(1);
    end
  end

  // Hold-off FSM with registered pulse and sticky flags; a set wins over clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ho_state  <= HO_IDLE;
      hold_cnt  <= '0;
      pulse_out <= 1'b0;
      pending   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pulse_out <= accept;
      pending   <= accept | (pending & ~clear);
      overrun   <= drop | (overrun & ~clear);
      case (ho_state)
        HO_IDLE: begin
          if (accept && (HOLDOFF > 0)) begin
            ho_state <= HO_HOLD;
            hold_cnt <= HOLD_W'(HOLDOFF);
          end
        end
        HO_HOLD: begin
          // Leaving on count 1 gives exactly HOLDOFF blocked cycles.
          hold_cnt <= hold_cnt - HOLD_W'(1);
          if (hold_cnt == HOLD_W'(1)) ho_state <= HO_IDLE;
        end
        default: ho_state <= HO_IDLE;
      endcase
    end
  end

`ifdef ASYNC_EDGE_COUNTER_EN
  logic [CNT_W-1:0] cnt_q;

  // Accepted-edge counter; counts alongside pulse_out and wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= CNT_W'(accept);
    end else begin
      cnt_q <= cnt_q + CNT_W'(accept);
    end
  end

  assign edge_count = cnt_q;
`else
  assign edge_count = '0;
`endif

endmodule

// File: rtl/async_edge_sync_multi.sv
// Multi-channel asynchronous edge synchroniser. Each of NCH async flags is
// synchronised into clk, edge-qualified per channel (rising/falling/both),
// subject to hold-off, and reported as a one-clk pulse with sticky pending
// and overrun flags. Per-channel edge counters exist only when
// ASYNC_EDGE_COUNTER_EN is defined; otherwise edge_count reads 0 and cnt_clr
// is ignored.
module async_edge_sync_multi
  import async_edge_pkg::*;
#(
  parameter int             NCH          = 4,
  parameter int             DEST_SYNC_FF = 4,
  parameter logic [NCH-1:0] EDGE_POS     = '1,
  parameter logic [NCH-1:0] EDGE_NEG     = '0,
  parameter int             HOLDOFF      = 0,
  parameter int             CNT_W        = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  async_edge_sync_multi_if.slave bus
);

  if (DEST_SYNC_FF < 2) begin : g_bad_depth
    $error("async_edge_sync_multi: DEST_SYNC_FF must be at least 2");
  end
  if ((NCH < 1) || (NCH > 32)) begin : g_bad_nch
    $error("async_edge_sync_multi: NCH must be in 1..32");
  end

  logic [NCH-1:0]       pulse_w;
  logic [NCH-1:0]       pending_w;
  logic [NCH-1:0]       overrun_w;
  logic [NCH*CNT_W-1:0] count_w;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    async_edge_sync_ch #(
      .DEST_SYNC_FF (DEST_SYNC_FF),
      .MODE         (edge_mode(EDGE_POS[k], EDGE_NEG[k])),
      .HOLDOFF      (HOLDOFF),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .a_flag     (bus.a_flag[k]),
      .clear      (bus.clear[k]),
`ifdef ASYNC_EDGE_COUNTER_EN
      .cnt_clr    (bus.cnt_clr),
`endif
      .pulse_out  (pulse_w[k]),
      .pending    (pending_w[k]),
      .overrun    (overrun_w[k]),
      .edge_count (count_w[k*CNT_W +: CNT_W])
    );
  end

  assign bus.pulse_out  = pulse_w;
  assign bus.pending    = pending_w;
  assign bus.overrun    = overrun_w;
  assign bus.edge_count = count_w;

endmodule

// File: tb/tb_async_edge_sync_multi.sv
// Bench for async_edge_sync_multi: ch0 rising, ch1 falling, ch2 both edges,
// ch3 disabled; HOLDOFF=8, DEST_SYNC_FF=4, CNT_W=4. A sample-history model
// predicts every output each cycle, alongside directed scenario checks.
module tb_async_edge_sync_multi;

  localparam int NCH   = 4;
  localparam int N     = 4;
  localparam int H     = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic reset_n;

  async_edge_sync_multi_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  async_edge_sync_multi #(
    .NCH          (NCH),
    .DEST_SYNC_FF (N),
    .EDGE_POS     (4'b0101),
    .EDGE_NEG     (4'b0110),
    .HOLDOFF      (H),
    .CNT_W        (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [NCH-1:0] pos_en = 4'b0101;
  logic [NCH-1:0] neg_en = 4'b0110;

  int checks = 0;
  int errors = 0;

  // Reference model: history of levels sampled at each clk edge since release.
  logic [NCH-1:0] hist[$];
  int             cyc;
  int             last_pulse[NCH];
  int             cnt_m[NCH];
  int             pcount[NCH];
  logic [NCH-1:0] pulse_m, pend_m, ovr_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0;
    hist.delete();
    hist.push_back('0);
    for (int c = 0; c < NCH; c++) begin
      last_pulse[c] = -1000;
      cnt_m[c]      = 0;
    end
    pulse_m = '0;
    pend_m  = '0;
    ovr_m   = '0;
  endtask

  // A level first sampled on edge t (differing from edge t-1's sample, with
  // t >= 2) yields a pulse on edge t+N-1; a pulse is blocked if one was
  // emitted within the previous H edges.
  task automatic model_edge();
    logic cur, prev, hit;
    cyc++;
    hist.push_back(bus.a_flag);
    for (int c = 0; c < NCH; c++) begin
      pulse_m[c] = 1'b0;
      hit = 1'b0;
      if (cyc - N >= 1) begin
        cur  = hist[cyc-N+1][c];
        prev = hist[cyc-N][c];
        hit  = (cur && !prev && pos_en[c]) || (!cur && prev && neg_en[c]);
      end
      if (hit && (cyc - last_pulse[c] > H)) begin
        pulse_m[c]    = 1'b1;
        last_pulse[c] = cyc;
      end
      pend_m[c] = pulse_m[c] | (pend_m[c] & ~bus.clear[c]);
      ovr_m[c]  = (hit & ~pulse_m[c]) | (ovr_m[c] & ~bus.clear[c]);
`ifdef ASYNC_EDGE_COUNTER_EN
      if (bus.cnt_clr) cnt_m[c] = pulse_m[c] ? 1 : 0;
      else             cnt_m[c] = (cnt_m[c] + int'(pulse_m[c])) % (1 << CNT_W);
`endif
    end
  endtask

  task automatic tick();
    logic [NCH*CNT_W-1:0] cexp;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int c = 0; c < NCH; c++) cexp[c*CNT_W +: CNT_W] = CNT_W'(cnt_m[c]);
    chk("pulse_out", bus.pulse_out, pulse_m);
    chk("pending", bus.pending, pend_m);
    chk("overrun", bus.overrun, ovr_m);
    chk("edge_count", bus.edge_count, cexp);
    for (int c = 0; c < NCH; c++) if (bus.pulse_out[c]) pcount[c]++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Call right after changing an input: the next edge samples it.
  task automatic expect_pulse_after(input int ch, input string tag);
    for (int i = 1; i < N; i++) begin
      tick();
      chk({tag, "_early"}, bus.pulse_out[ch], 1'b0);
    end
    tick();
    chk({tag, "_fire"}, bus.pulse_out[ch], 1'b1);
    tick();
    chk({tag, "_width"}, bus.pulse_out[ch], 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pulse"}, bus.pulse_out, '0);
    chk({tag, "_pending"}, bus.pending, '0);
    chk({tag, "_overrun"}, bus.overrun, '0);
    chk({tag, "_count"}, bus.edge_count, '0);
  endtask

  initial begin
    int pc;
    reset_n     = 1'b0;
    bus.a_flag  = '0;
    bus.clear   = '0;
    bus.cnt_clr = 1'b0;
    for (int c = 0; c < NCH; c++) pcount[c] = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    ticks(10);

    // ch0 rising edge latency and pending, others quiet
    bus.a_flag[0] = 1'b1;
    expect_pulse_after(0, "ch0_rise");
    chk("ch0_pending", bus.pending[0], 1'b1);
    chk("others_pending", bus.pending[3:1], 3'b000);

    // ch1 falling-only: a 10-cycle high pulse gives one pulse, from the fall
    pc = pcount[1];
    bus.a_flag[1] = 1'b1;
    ticks(10);
    bus.a_flag[1] = 1'b0;
    expect_pulse_after(1, "ch1_fall");
    ticks(4);
    chk("ch1_pulse_count", pcount[1] - pc, 1);

    // ch2 both edges, hold-off: 3 apart drops one, 9 apart keeps both
    pc = pcount[2];
    bus.a_flag[2] = 1'b1;
    ticks(3);
    bus.a_flag[2] = 1'b0;
    ticks(15);
    chk("ch2_close_pulses", pcount[2] - pc, 1);
    chk("ch2_overrun_set", bus.overrun[2], 1'b1);
    bus.clear[2] = 1'b1;
    tick();
    bus.clear[2] = 1'b0;
    chk("ch2_overrun_clr", bus.overrun[2], 1'b0);
    pc = pcount[2];
    bus.a_flag[2] = 1'b1;
    ticks(9);
    bus.a_flag[2] = 1'b0;
    ticks(15);
    chk("ch2_far_pulses", pcount[2] - pc, 2);
    chk("ch2_no_overrun", bus.overrun[2], 1'b0);

    // all channels change together: every enabled channel pulses on one cycle
    bus.a_flag = 4'b0010;
    ticks(20);
    bus.a_flag = 4'b1101;
    ticks(N - 1);
    tick();
    chk("simultaneous", bus.pulse_out, 4'b0111);
    ticks(3);

    // clear coincident with the setting pulse: set wins, next clear takes
    bus.a_flag[0] = 1'b0;
    ticks(20);
    bus.clear = '1;
    tick();
    bus.clear = '0;
    bus.a_flag[0] = 1'b1;
    ticks(N - 1);
    bus.clear[0] = 1'b1;
    tick();
    chk("clr_coincident_pulse", bus.pulse_out[0], 1'b1);
    chk("clr_coincident_pend", bus.pending[0], 1'b1);
    tick();
    bus.clear[0] = 1'b0;
    chk("clr_next_pend", bus.pending[0], 1'b0);

    // counter wrap after 17 rising edges, then cnt_clr coincident with a pulse
    bus.a_flag[0] = 1'b0;
    ticks(12);
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.a_flag[0] = 1'b1;
      ticks(6);
      bus.a_flag[0] = 1'b0;
      ticks(6);
    end
`ifdef ASYNC_EDGE_COUNTER_EN
    chk("count_wrap", bus.edge_count[CNT_W-1:0], 4'd1);
`else
    chk("count_absent", bus.edge_count, '0);
`endif
    bus.a_flag[0] = 1'b1;
    ticks(N - 1);
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
`ifdef ASYNC_EDGE_COUNTER_EN
    chk("cnt_clr_with_pulse", bus.edge_count[CNT_W-1:0], 4'd1);
`else
    chk("cnt_clr_ignored", bus.edge_count, '0);
`endif
    ticks(12);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) bus.a_flag[$urandom_range(0, NCH - 1)] ^= 1'b1;
      bus.clear   = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
      bus.cnt_clr = ($urandom_range(0, 31) == 0);
      tick();
    end
    bus.clear   = '0;
    bus.cnt_clr = 1'b0;
    ticks(20);

    // reset in the middle of a ch2 hold-off window
    bus.a_flag[2] = ~bus.a_flag[2];
    expect_pulse_after(2, "pre_reset");
    chk("pending_pre_reset", bus.pending[2], 1'b1);
    bus.a_flag = 4'b1111;
    #2 reset_n = 1'b0;
    #1 chk_zero("async_reset");
    @(posedge clk);
    #1 chk_zero("held_reset");
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    tick();
    bus.a_flag[2] = 1'b0;
    expect_pulse_after(2, "post_reset");
    ticks(12);
    chk("ch3_silent", pcount[3], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
